phase_seq_timer: RTL
====================

// Module: phase_seq_timer
// PURPOSE
//  Parametrised N-phase countdown sequencer, successor to the single-channel light counter.
//  - Owns the phase index, per-phase reloadable durations, an internal tick prescaler and
//    forced phase jumps, so the light FSM only decodes outputs.
//  - Sits between the clock/enable source and the traffic-light output decoder.
// PARAMETERS
//  pNUM_PHASES  3                    number of phases, >=2; phase 0 = GREEN, 1 = YELLOW, 2 = RED
//  pCNT_WIDTH   5                    countdown width
//  pTICK_DIV    1                    enabled clk cycles per count tick, >=1
//  pDUR_INIT    {5'd17,5'd2,5'd14}   packed reset durations, phase i at [i*pCNT_WIDTH +: pCNT_WIDTH]
//  localparam pPH_WIDTH = $clog2(pNUM_PHASES)
// PORTS
//  clk          in   1            clock
//  rst_n        in   1            async active-low reset
//  en           in   1            run enable; low freezes counter and prescaler
//  cfg_we       in   1            duration table write strobe
//  cfg_idx      in   pPH_WIDTH    phase to write
//  cfg_val      in   pCNT_WIDTH   new duration
//  force_load   in   1            jump to force_phase
//  force_phase  in   pPH_WIDTH    target phase
//  phase        out  pPH_WIDTH    current phase
//  count_out    out  pCNT_WIDTH   remaining ticks in phase
//  last         out  1            count_out==0
//  pre_last     out  1            count_out==1
//  phase_done   out  1            1-cycle pulse on phase advance
//  cycle_wrap   out  1            1-cycle pulse on advance from pNUM_PHASES-1 to 0
// BEHAVIOUR
//  Reset: all state is cleared asynchronously when rst_n goes low.
//  - dur[i] = pDUR_INIT slice; phase = 0; count = dur[0]; prescaler = 0.
//  - phase_done = 0, cycle_wrap = 0; last and pre_last are derived from count.
//  Tick:
//  - With en=1 the prescaler counts 0..pTICK_DIV-1.
//  - tick = en && (div == pTICK_DIV-1); div then returns to 0.
//  - pTICK_DIV=1 gives tick = en.
//  - With en=0, div and count hold.
//  On tick:
//  - If count!=0: count decrements by 1, with no wrap below 0.
//  - If count==0: phase advances to (phase+1) mod pNUM_PHASES and count loads dur[next].
//  - On that advance, phase_done pulses; cycle_wrap also pulses if phase was pNUM_PHASES-1.
//  - A phase therefore lasts dur+1 ticks; dur=0 gives a 1-tick phase.
//  force_load: highest priority, and acts regardless of en.
//  - Next edge: phase = force_phase, count = dur[force_phase], div = 0.
//  - No phase_done or cycle_wrap pulse is generated.
//  - If force_phase >= pNUM_PHASES the request is ignored entirely.
//  cfg_we:
//  - dur[cfg_idx] <= cfg_val at the next edge.
//  - cfg_idx >= pNUM_PHASES is ignored.
//  - The write never alters the running count; it takes effect at the next load of that phase.
//  - Write in the same cycle as a load of the same phase: the load uses cfg_val (bypass).
//  Outputs are registered state or direct decodes of it; latency from tick/force to outputs is 1 clk.
// STRUCTURE
//  Shared include file traffic_defs.vh holds:
//  - phase index constants (PH_GREEN=0, PH_YELLOW=1, PH_RED=2);
//  - default durations (14, 2, 17);
//  - the pCNT_WIDTH default.
//  Sub-module tick_prescaler (params pTICK_DIV; ports clk, rst_n, en, clr, tick); clr is driven by force_load.
//  Duration table, phase register and countdown live in phase_seq_timer.
// TESTING
//  1 Reset, defaults -> phase=0, count_out=14, last=0, pre_last=0, no pulses.
//  2 pTICK_DIV=1, en=1 -> count 14..0 over 14 clks; next clk phase=1, count=2, phase_done=1;
//    after RED 17..0 -> phase=0, count=14, cycle_wrap=1 and phase_done=1.
//  3 pTICK_DIV=4 -> count decrements every 4th en cycle; en=0 for 3 clks mid-interval
//    freezes div, and the next decrement is delayed by exactly 3 clks.
//  4 phase 0, count=7, force_load with force_phase=2 -> next clk phase=2, count=17, no pulses;
//    force_phase=3 -> no change.
//  5 cfg write dur[1]=5 during phase 0 -> YELLOW loads 5; dur[0]=9 written during phase 0 ->
//    count unaffected; write dur[1]=6 on the advance clk -> count=6.
//  6 rst_n low between edges mid-count -> outputs reset immediately; dur table returns to 14/2/17.

Source files
------------

// File: rtl/phase_seq_timer_pkg.sv
// Shared constants for the traffic-light phase sequencer: phase indices,
// default durations and the default countdown width.
package phase_seq_timer_pkg;

  typedef enum logic [1:0] {
    TL_GREEN  = 2'd0,
    TL_YELLOW = 2'd1,
    TL_RED    = 2'd2
  } tl_phase_e;

  localparam int PH_GREEN  = 0;
  localparam int PH_YELLOW = 1;
  localparam int PH_RED    = 2;

  localparam int DEF_CNT_WIDTH  = 5;
  localparam int DEF_DUR_GREEN  = 14;
  localparam int DEF_DUR_YELLOW = 2;
  localparam int DEF_DUR_RED    = 17;

  // Phase i occupies bits [i*DEF_CNT_WIDTH +: DEF_CNT_WIDTH].
  localparam logic [3*DEF_CNT_WIDTH-1:0] DEF_DUR_INIT = {
    DEF_CNT_WIDTH'(DEF_DUR_RED),
    DEF_CNT_WIDTH'(DEF_DUR_YELLOW),
    DEF_CNT_WIDTH'(DEF_DUR_GREEN)
  };

endpackage

// File: rtl/phase_seq_timer_tick_prescaler.sv
// Count-tick prescaler: emits one tick every pTICK_DIV enabled cycles.
// clr restarts the interval regardless of en.
module tick_prescaler #(
  parameter int pTICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DW = (pTICK_DIV > 1) ? $clog2(pTICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(pTICK_DIV - 1);

  logic [DW-1:0] div;

  // With pTICK_DIV=1 div stays at 0, so tick collapses to en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        div <= '0;
    else if (clr)      div <= '0;
    else if (en)       div <= (div == DIV_MAX) ? '0 : div + DW'(1);
  end

  assign tick = en && (div == DIV_MAX);

endmodule

// File: rtl/phase_seq_timer.sv
// N-phase countdown sequencer: owns the phase index, reloadable duration table,
// countdown and forced jumps; the light decoder only decodes phase/count.
module phase_seq_timer
  import phase_seq_timer_pkg::*;
#(
  parameter int pNUM_PHASES = 3,
  parameter int pCNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int pTICK_DIV   = 1,
  parameter logic [pNUM_PHASES*pCNT_WIDTH-1:0] pDUR_INIT = DEF_DUR_INIT,
  localparam int pPH_WIDTH  = $clog2(pNUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  cfg_we,
  input  logic [pPH_WIDTH-1:0]  cfg_idx,
  input  logic [pCNT_WIDTH-1:0] cfg_val,
  input  logic                  force_load,
  input  logic [pPH_WIDTH-1:0]  force_phase,
  output logic [pPH_WIDTH-1:0]  phase,
  output logic [pCNT_WIDTH-1:0] count_out,
  output logic                  last,
  output logic                  pre_last,
  output logic                  phase_done,
  output logic                  cycle_wrap
);

  localparam logic [pPH_WIDTH:0]   NUM_EXT = (pPH_WIDTH+1)'(pNUM_PHASES);
  localparam logic [pPH_WIDTH-1:0] LAST_PH = pPH_WIDTH'(pNUM_PHASES - 1);

  logic [pCNT_WIDTH-1:0] dur [pNUM_PHASES];
  logic                  tick;
  logic                  force_ok, cfg_ok;
  logic [pPH_WIDTH-1:0]  next_phase, load_phase;
  logic [pCNT_WIDTH-1:0] load_val;

  // Out-of-range indices drop the whole request.
  assign force_ok = force_load && ({1'b0, force_phase} < NUM_EXT);
  assign cfg_ok   = cfg_we     && ({1'b0, cfg_idx}     < NUM_EXT);

  tick_prescaler #(.pTICK_DIV(pTICK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (force_ok),
    .tick  (tick)
  );

  assign next_phase = (phase == LAST_PH) ? '0 : phase + pPH_WIDTH'(1);
  assign load_phase = force_ok ? force_phase : next_phase;
  // A same-cycle table write to the phase being loaded wins over the stored value.
  assign load_val   = (cfg_ok && (cfg_idx == load_phase)) ? cfg_val : dur[load_phase];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < pNUM_PHASES; i++)
        dur[i] <= pDUR_INIT[i*pCNT_WIDTH +: pCNT_WIDTH];
    end else if (cfg_ok) begin
      dur[cfg_idx] <= cfg_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= '0;
      count_out  <= pDUR_INIT[pCNT_WIDTH-1:0];
      phase_done <= 1'b0;
      cycle_wrap <= 1'b0;
    end else begin
      phase_done <= 1'b0;
      cycle_wrap <= 1'b0;
      if (force_ok) begin
        phase     <= force_phase;
        count_out <= load_val;
      end else if (tick) begin
        if (count_out != '0) begin
          count_out <= count_out - pCNT_WIDTH'(1);
        end else begin
          phase      <= next_phase;
          count_out  <= load_val;
          phase_done <= 1'b1;
          cycle_wrap <= (phase == LAST_PH);
        end
      end
    end
  end

  assign last     = (count_out == '0);
  assign pre_last = (count_out == pCNT_WIDTH'(1));

endmodule
